lsu_ctrl: RTL and testbench

Load/store sequencer sitting behind the execute-stage ALU decode. It takes one decoded memory request per transaction (read/write strobes, width type, adder-computed address, store data), drives a single-outstanding valid/ready data bus, and holds the pipeline until the response returns. It also aligns and extends load data for writeback and flags misaligned accesses and bus faults.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/lsu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: FSM encoding, strobe bit
// positions, byte-enable patterns and the load-type decode helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

    // Bit positions inside the one-hot store type {sb,sh,sw}
    localparam int WT_SB = 2;
    localparam int WT_SH = 1;
    localparam int WT_SW = 0;

    // Bit positions inside the load type {lb|lh, lbu|lb, lhu|lh, lw}
    localparam int RD_SIGNED = 3;
    localparam int RD_BYTE   = 2;
    localparam int RD_HALF   = 1;
    localparam int RD_WORD   = 0;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic lw;
        logic lb;
        logic lh;
        logic lbu;
        logic lhu;
    } ld_kind_t;

    function automatic ld_kind_t decode_rdtype(input logic [3:0] rdtype);
        ld_kind_t k;
        k.lw  = rdtype[RD_WORD];
        k.lb  = rdtype[RD_SIGNED] &  rdtype[RD_BYTE];
        k.lh  = rdtype[RD_SIGNED] &  rdtype[RD_HALF];
        k.lbu = rdtype[RD_BYTE]   & ~rdtype[RD_SIGNED];
        k.lhu = rdtype[RD_HALF]   & ~rdtype[RD_SIGNED];
        return k;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner: shifts the addressed lane down to bit 0
// and sign- or zero-extends it according to the load type.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  rdtype,
    output logic [31:0] wb_data
);

    logic [31:0] shifted;
    ld_kind_t    kind;

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign kind    = decode_rdtype(rdtype);

    // NOTE: wb_data gets a default before any branch so no latch is inferred.
    always_comb begin
        wb_data = shifted;
        if (kind.lw)
            wb_data = shifted;
        else if (kind.lb)
            wb_data = {{24{shifted[7]}}, shifted[7:0]};
        else if (kind.lh)
            wb_data = {{16{shifted[15]}}, shifted[15:0]};
        else if (kind.lbu)
            wb_data = {24'd0, shifted[7:0]};
        else if (kind.lhu)
            wb_data = {16'd0, shifted[15:0]};
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: single-outstanding valid/ready bus master with load
// alignment, misalign detection and bus-fault reporting.
// Optional watchdog enabled by defining LSU_CTRL_TIMEOUT_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_mem_wreq,
    input  logic        i_mem_rreq,
    input  logic [2:0]  i_mem_wtype,
    input  logic [3:0]  i_mem_rdtype,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic        o_misalign,
    output logic        o_fault
);

    lsu_state_e  state, state_next;
    logic        is_store, misaligned;
    logic [1:0]  off;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        accept, misalign_det, done_ok, done_err, tmo_fire, tmo_hit;
    logic [3:0]  rdtype_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] align_data;

    assign is_store = i_mem_wreq;
    assign off      = i_addr[1:0];

    always_comb begin
        st_be    = BE_NONE;
        st_wdata = i_wdata;
        if (i_mem_wtype[WT_SB]) begin
            st_be    = BE_BYTE0 << off;
            st_wdata = {4{i_wdata[7:0]}};
        end else if (i_mem_wtype[WT_SH]) begin
            st_be    = off[1] ? BE_HALF_HI : BE_HALF_LO;
            st_wdata = {2{i_wdata[15:0]}};
        end else if (i_mem_wtype[WT_SW]) begin
            st_be    = BE_WORD;
        end
    end

    // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
    assign misaligned = is_store
        ? ((i_mem_wtype[WT_SH] & off[0]) | (i_mem_wtype[WT_SW] & (|off)))
        : ((i_mem_rdtype[RD_HALF] & off[0]) | (i_mem_rdtype[RD_WORD] & (|off)));

`ifdef LSU_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change, so REQ and RSP are timed separately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            tmo_cnt <= '0;
        else if (state_next != state)
            tmo_cnt <= '0;
        else if (state != IDLE)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        misalign_det = 1'b0;
        done_ok      = 1'b0;
        done_err     = 1'b0;
        tmo_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid && (i_mem_wreq || i_mem_rreq)) begin
                    if (misaligned) begin
                        misalign_det = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (i_bus_ready)
                    state_next = RSP;
            end
            RSP: begin
                if (i_bus_rvalid) begin
                    state_next = IDLE;
                    done_ok    = ~i_bus_err;
                    done_err   = i_bus_err;
                end
            end
            default: state_next = IDLE;
        endcase
        // A real bus event in the same cycle wins over the watchdog.
        if (tmo_hit && (state_next == state)) begin
            tmo_fire   = 1'b1;
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bus_valid <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_be    <= BE_NONE;
            o_wb_valid  <= 1'b0;
            o_wb_data   <= '0;
            o_misalign  <= 1'b0;
            o_fault     <= 1'b0;
            rdtype_q    <= '0;
            addr_lo_q   <= '0;
        end else begin
            o_bus_valid <= (state_next == REQ);
            o_wb_valid  <= done_ok;
            o_misalign  <= misalign_det;
            o_fault     <= done_err | tmo_fire;
            if (accept) begin
                o_bus_we    <= is_store;
                o_bus_addr  <= {i_addr[31:2], 2'b00};
                o_bus_be    <= is_store ? st_be : BE_NONE;
                o_bus_wdata <= is_store ? st_wdata : 32'd0;
                rdtype_q    <= i_mem_rdtype;
                addr_lo_q   <= off;
            end
            if (done_ok)
                o_wb_data <= o_bus_we ? 32'd0 : align_data;
        end
    end

    lsu_load_align u_align (
        .rdata   (i_bus_rdata),
        .addr_lo (addr_lo_q),
        .rdtype  (rdtype_q),
        .wb_data (align_data)
    );

    assign o_req_ready = (state == IDLE);
    assign o_stall     = (state != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed test-plan steps followed by
// randomized loads/stores compared against a byte-level reference model.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_mem_wreq;
    logic        i_mem_rreq;
    logic [2:0]  i_mem_wtype;
    logic [3:0]  i_mem_rdtype;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic        o_fault;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] T_SB = 3'b100, T_SH = 3'b010, T_SW = 3'b001;
    localparam logic [3:0] T_LB = 4'b1100, T_LBU = 4'b0100, T_LH = 4'b1010,
                           T_LHU = 4'b0010, T_LW = 4'b0001;

    lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_mem_wreq   (i_mem_wreq),
        .i_mem_rreq   (i_mem_rreq),
        .i_mem_wtype  (i_mem_wtype),
        .i_mem_rdtype (i_mem_rdtype),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_bus_valid  (o_bus_valid),
        .i_bus_ready  (i_bus_ready),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_be     (o_bus_be),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_err    (i_bus_err),
        .o_wb_valid   (o_wb_valid),
        .o_wb_data    (o_wb_data),
        .o_misalign   (o_misalign),
        .o_fault      (o_fault)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: access size and lane arithmetic straight from the
    // byte-addressed memory view, independent of any encoding in the DUT.
    task automatic model(input bit st, input logic [2:0] wt, input logic [3:0] rt,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         output bit mis, output logic [3:0] be, output logic [31:0] bwd,
                         output logic [31:0] wbd);
        int size, o;
        bit sgn;
        longint v;
        o   = int'(addr[1:0]);
        sgn = 1'b0;
        if (st) size = (wt == T_SB) ? 1 : (wt == T_SH) ? 2 : 4;
        else begin
            case (rt)
                T_LB:    begin size = 1; sgn = 1'b1; end
                T_LBU:   size = 1;
                T_LH:    begin size = 2; sgn = 1'b1; end
                T_LHU:   size = 2;
                default: size = 4;
            endcase
        end
        mis = (o % size) != 0;
        be  = 4'b0000;
        bwd = 32'd0;
        wbd = 32'd0;
        if (st) begin
            for (int i = 0; i < 4; i++) begin
                be[i] = (i >= o) && (i < o + size);
                bwd[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end else begin
            v = longint'(rd >> (8 * o)) % (longint'(1) << (8 * size));
            if (sgn && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            wbd = v[31:0];
        end
    endtask

    task automatic do_op(input bit st, input bit both, input logic [2:0] wt, input logic [3:0] rt,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int dly, input bit err);
        bit          mis;
        logic [3:0]  be;
        logic [31:0] bwd, wbd;
        model(st, wt, rt, addr, wd, rd, mis, be, bwd, wbd);
        check("req_ready_idle", o_req_ready, 1);
        i_req_valid  = 1'b1;
        i_mem_wreq   = st;
        i_mem_rreq   = !st || both;
        i_mem_wtype  = wt;
        i_mem_rdtype = rt;
        i_addr       = addr;
        i_wdata      = wd;
        step();
        i_req_valid = 1'b0;
        i_mem_wreq  = 1'b0;
        i_mem_rreq  = 1'b0;
        i_addr      = ~addr;
        i_wdata     = ~wd;
        i_mem_rdtype = ~rt;
        if (mis) begin
            check("misalign_pulse", o_misalign, 1);
            check("misalign_no_bus", o_bus_valid, 0);
            check("misalign_no_stall", o_stall, 0);
            check("misalign_ready", o_req_ready, 1);
            step();
            check("misalign_once", o_misalign, 0);
            check("misalign_no_bus2", o_bus_valid, 0);
            return;
        end
        check("no_misalign", o_misalign, 0);
        check("bus_valid", o_bus_valid, 1);
        check("stall_req", o_stall, 1);
        check("bus_we", o_bus_we, st);
        check("bus_addr", o_bus_addr, {addr[31:2], 2'b00});
        check("bus_be", o_bus_be, be);
        if (st) check("bus_wdata", o_bus_wdata, bwd);
        for (int i = 0; i < dly; i++) begin
            i_bus_rvalid = (i == 0);
            step();
            i_bus_rvalid = 1'b0;
            check("hold_valid", o_bus_valid, 1);
            check("hold_addr", o_bus_addr, {addr[31:2], 2'b00});
            check("hold_be", o_bus_be, be);
            if (st) check("hold_wdata", o_bus_wdata, bwd);
            check("stray_rsp_ignored", o_wb_valid, 0);
        end
        i_bus_ready = 1'b1;
        step();
        i_bus_ready = 1'b0;
        check("rsp_valid_drop", o_bus_valid, 0);
        check("stall_rsp", o_stall, 1);
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = rd;
        i_bus_err    = err;
        step();
        i_bus_rvalid = 1'b0;
        i_bus_err    = 1'b0;
        i_bus_rdata  = $urandom;
        check("wb_valid", o_wb_valid, !err);
        check("fault", o_fault, err);
        check("stall_done", o_stall, 0);
        check("ready_done", o_req_ready, 1);
        if (!err) check("wb_data", o_wb_data, wbd);
        step();
        check("wb_valid_pulse", o_wb_valid, 0);
        check("fault_pulse", o_fault, 0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = 1'b0;
        i_mem_wreq   = 1'b0;
        i_mem_rreq   = 1'b0;
        i_mem_wtype  = 3'b000;
        i_mem_rdtype = 4'b0000;
        i_addr       = 32'd0;
        i_wdata      = 32'd0;
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        i_bus_rdata  = 32'd0;
        i_bus_err    = 1'b0;
        #12;
        check("rst_bus_valid", o_bus_valid, 0);
        check("rst_bus_we", o_bus_we, 0);
        check("rst_bus_addr", o_bus_addr, 0);
        check("rst_bus_wdata", o_bus_wdata, 0);
        check("rst_bus_be", o_bus_be, 0);
        check("rst_wb", {o_wb_valid, o_misalign, o_fault}, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_stall", o_stall, 0);
        check("rst_ready", o_req_ready, 1);
        step();
        i_rst = 1'b0;
        step();

        // lw at 0x1000, immediate ready
        do_op(1'b0, 1'b0, 3'b000, T_LW, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        check("lw_data", o_wb_data, 32'hDEAD_BEEF);
        // lb / lbu at 0x1003
        do_op(1'b0, 1'b0, 3'b000, T_LB, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 1'b0);
        check("lb_data", o_wb_data, 32'hFFFF_FF80);
        do_op(1'b0, 1'b0, 3'b000, T_LBU, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 1'b0);
        check("lbu_data", o_wb_data, 32'h0000_0080);
        // sh at 0x2002 with ready delayed three cycles
        do_op(1'b1, 1'b0, T_SH, 4'b0000, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1'b0);
        check("sh_be", o_bus_be, 4'b1100);
        check("sh_wdata", o_bus_wdata, 32'hABCD_ABCD);
        check("sh_wb_data", o_wb_data, 32'd0);
        // misaligned lw
        do_op(1'b0, 1'b0, 3'b000, T_LW, 32'h0000_3001, 32'd0, 32'd0, 0, 1'b0);
        // write priority: both strobes set, store wins
        do_op(1'b1, 1'b1, T_SB, T_LW, 32'h0000_4001, 32'h0000_005A, 32'd0, 1, 1'b0);
        check("prio_we", o_bus_we, 1);
        // bus error on lw
        do_op(1'b0, 1'b0, 3'b000, T_LW, 32'h0000_5000, 32'd0, 32'h1111_2222, 0, 1'b1);

        // stray response in IDLE
        i_bus_rvalid = 1'b1;
        step();
        i_bus_rvalid = 1'b0;
        check("idle_rsp_ignored", o_wb_valid, 0);
        check("idle_rsp_stall", o_stall, 0);

        // reset asserted while waiting in REQ
        i_req_valid  = 1'b1;
        i_mem_rreq   = 1'b1;
        i_mem_rdtype = T_LW;
        i_addr       = 32'h0000_6000;
        step();
        i_req_valid = 1'b0;
        i_mem_rreq  = 1'b0;
        check("pre_rst_valid", o_bus_valid, 1);
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_valid", o_bus_valid, 0);
        check("async_rst_stall", o_stall, 0);
        #1 i_rst = 1'b0;
        step();
        check("post_rst_wb", o_wb_valid, 0);
        check("post_rst_fault", o_fault, 0);
        check("post_rst_ready", o_req_ready, 1);

`ifdef LSU_CTRL_TIMEOUT_EN
        // watchdog: no response, fault after 16 RSP cycles
        i_req_valid  = 1'b1;
        i_mem_rreq   = 1'b1;
        i_mem_rdtype = T_LW;
        i_addr       = 32'h0000_7000;
        step();
        i_req_valid = 1'b0;
        i_mem_rreq  = 1'b0;
        i_bus_ready = 1'b1;
        step();
        i_bus_ready = 1'b0;
        check("tmo_in_rsp", o_stall, 1);
        repeat (15) step();
        check("tmo_not_early", o_fault, 0);
        step();
        check("tmo_fault", o_fault, 1);
        check("tmo_idle", o_stall, 0);
        i_bus_rvalid = 1'b1;
        step();
        i_bus_rvalid = 1'b0;
        check("tmo_late_rsp", o_wb_valid, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            bit          st, both, err;
            logic [2:0]  wt;
            logic [3:0]  rt;
            int          sel;
            st   = 1'($urandom_range(0, 1));
            both = st && ($urandom_range(0, 3) == 0);
            err  = ($urandom_range(0, 7) == 0);
            sel  = int'($urandom_range(0, 2));
            wt   = st ? ((sel == 0) ? T_SB : (sel == 1) ? T_SH : T_SW) : 3'b000;
            case ($urandom_range(0, 4))
                0: rt = T_LB;
                1: rt = T_LBU;
                2: rt = T_LH;
                3: rt = T_LHU;
                default: rt = T_LW;
            endcase
            if (st && !both) rt = 4'b0000;
            do_op(st, both, wt, rt, $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 2)), err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
